// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state and read-owner encodings.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    EXT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_e;

  // Bits needed to hold the values 0..max (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with a priority clear; used as the host starvation counter.
module sat_counter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX = 4,
  localparam int unsigned W = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // Count up on inc until MAX is reached; clr wins over inc.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + 1'b1;
    end
  end

  // Saturation flag seen by the arbiter.
  always_comb begin
    at_max = (count == MAX_V);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data SRAM arbiter between the CPU MEM stage and the host port.
// CPU has fixed priority; the starvation counter forces a host slot.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CW = cnt_width(STARVE_MAX);
  localparam logic [CW-1:0] STARVE_V = CW'(STARVE_MAX);

  state_e        state_q, state_d;
  logic          ext_win, cpu_win;
  logic [CW-1:0] starve_cnt;
  logic          starve_full;
  logic          rd_pend;
  owner_e        rd_owner;

  sat_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .arst   (arst),
    .inc    (ext_req & ~ext_win),
    .clr    (ext_win),
    .count  (starve_cnt),
    .at_max (starve_full)
  );

  // Same-cycle grant: host wins when the CPU is idle or the host has starved long enough.
  always_comb begin
    ext_win = ext_req & (~cpu_req | starve_full);
    cpu_win = cpu_req & ~ext_win;
    assert (starve_full == (starve_cnt == STARVE_V));
  end

  // State register: remembers the last owner of the SRAM.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows the winner and holds when nobody requests.
  always_comb begin
    state_d = state_q;
    if (ext_win) begin
      state_d = EXT;
    end else if (cpu_win) begin
      state_d = CPU;
    end
  end

  // Output decode: drive the SRAM from the winner and flag the denied CPU.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    if (ext_win) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_wen   = ext_wen;
      mem_ren   = ~ext_wen;
    end else if (cpu_win) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = cpu_wen;
      mem_ren   = ~cpu_wen;
    end
    ext_gnt   = ext_win;
    cpu_stall = cpu_req & ~cpu_win;
  end

  // Read-return tracking: every cycle's issue overwrites the pending slot.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWN_CPU;
    end else begin
      rd_pend <= mem_ren;
      if (mem_ren) begin
        rd_owner <= ext_win ? OWN_EXT : OWN_CPU;
      end
    end
  end

  // Route SRAM read data to the requester that issued the read.
  always_comb begin
    cpu_rvalid = rd_pend & (rd_owner == OWN_CPU);
    ext_rvalid = rd_pend & (rd_owner == OWN_EXT);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    ext_rdata  = ext_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural single-port SRAM.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        arst;
  logic        cpu_req, cpu_wen, ext_req, ext_wen;
  logic [9:0]  cpu_addr, ext_addr, mem_addr;
  logic [31:0] cpu_wdata, ext_wdata, cpu_rdata, ext_rdata, mem_wdata, mem_rdata;
  logic        cpu_rvalid, cpu_stall, ext_gnt, ext_rvalid, mem_wen, mem_ren;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct { logic [31:0] data; int cyc; } exp_t;
  exp_t cpu_q[$];
  exp_t ext_q[$];

  logic [31:0] sram [0:1023];

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .arst(arst),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: write on wen, registered read data one cycle after ren.
  always @(posedge clk) begin
    if (mem_wen) sram[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= sram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive, then check grant/SRAM decode and queue any expected read return.
  task automatic step(input logic creq, input logic cwen, input logic [9:0] caddr,
                      input logic [31:0] cwd, input logic ereq, input logic ewen,
                      input logic [9:0] eaddr, input logic [31:0] ewd,
                      input logic exp_stall, input logic exp_gnt,
                      input logic [31:0] exp_data, input bit push);
    logic w_any, w_wen;
    logic [9:0] w_addr;
    logic [31:0] w_wd;
    exp_t e;
    @(posedge clk);
    #1;
    cpu_req = creq; cpu_wen = cwen; cpu_addr = caddr; cpu_wdata = cwd;
    ext_req = ereq; ext_wen = ewen; ext_addr = eaddr; ext_wdata = ewd;
    #3;
    check("cpu_stall", {31'b0, cpu_stall}, {31'b0, exp_stall});
    check("ext_gnt", {31'b0, ext_gnt}, {31'b0, exp_gnt});
    w_any = exp_gnt | creq;
    w_wen = exp_gnt ? ewen : cwen;
    w_addr = exp_gnt ? eaddr : (creq ? caddr : 10'd0);
    w_wd = exp_gnt ? ewd : (creq ? cwd : 32'd0);
    check("mem_wen", {31'b0, mem_wen}, {31'b0, w_any & w_wen});
    check("mem_ren", {31'b0, mem_ren}, {31'b0, w_any & ~w_wen});
    check("mem_addr", {22'b0, mem_addr}, {22'b0, w_addr});
    check("mem_wdata", mem_wdata, w_wd);
    if (w_any && !w_wen && push) begin
      e.data = exp_data;
      e.cyc = cyc + 1;
      if (exp_gnt) ext_q.push_back(e);
      else cpu_q.push_back(e);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Both requesters held: CPU for four cycles, host forced on the fifth, CPU again after.
  task automatic contention();
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 10'd20, 32'hA0A0_0000 + i, 1, 1, 10'd21, 32'hB0B0_B0B0,
           (i == 4), (i == 4), 0, 0);
    end
    idle();
  endtask

  // Monitor: pop and compare whenever a read return is presented.
  always @(negedge clk) begin
    exp_t e;
    if (!arst) begin
      if (cpu_rvalid) begin
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = cpu_q.pop_front();
          check("cpu_rdata", cpu_rdata, e.data);
          check("cpu_rvalid_cycle", cyc, e.cyc);
        end
      end else begin
        check("cpu_rdata_idle", cpu_rdata, 32'd0);
      end
      if (cpu_q.size() > 0 && cpu_q[0].cyc < cyc) begin
        e = cpu_q.pop_front();
        checks++; errors++;
        $display("FAIL cpu_rvalid_missing: got 0 expected 1 at cycle %0d", e.cyc);
      end
      if (ext_rvalid) begin
        if (ext_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ext_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = ext_q.pop_front();
          check("ext_rdata", ext_rdata, e.data);
          check("ext_rvalid_cycle", cyc, e.cyc);
        end
      end else begin
        check("ext_rdata_idle", ext_rdata, 32'd0);
      end
      if (ext_q.size() > 0 && ext_q[0].cyc < cyc) begin
        e = ext_q.pop_front();
        checks++; errors++;
        $display("FAIL ext_rvalid_missing: got 0 expected 1 at cycle %0d", e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst = 1'b1;
    cpu_req = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 1; ext_wen = 0; ext_addr = 0; ext_wdata = 0;
    #4;
    // Reset values; grant/stall still follow the requests.
    check("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    check("rst_ext_rvalid", {31'b0, ext_rvalid}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_ext_rdata", ext_rdata, 32'd0);
    check("rst_ext_gnt", {31'b0, ext_gnt}, 32'd1);
    ext_req = 0; cpu_req = 1; #1;
    check("rst_cpu_stall", {31'b0, cpu_stall}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0; cpu_req = 0;

    // Preload through the host port.
    step(0, 0, 0, 0, 1, 1, 10'd5, 32'hDEAD_BEEF, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 10'd1, 32'h1111_1111, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 10'd2, 32'h2222_2222, 0, 1, 0, 0);
    idle();

    // CPU read, no host.
    step(1, 0, 10'd5, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 1);
    idle();

    // Host write then CPU read of the same address.
    step(0, 0, 0, 0, 1, 1, 10'd7, 32'h0000_1234, 0, 1, 0, 0);
    step(1, 0, 10'd7, 0, 0, 0, 0, 0, 0, 0, 32'h0000_1234, 1);
    idle();

    // Alternating owners back to back.
    step(1, 0, 10'd1, 0, 0, 0, 0, 0, 0, 0, 32'h1111_1111, 1);
    step(0, 0, 0, 0, 1, 0, 10'd2, 0, 0, 1, 32'h2222_2222, 1);
    idle();

    // Starvation forcing, then read back what both sides wrote.
    contention();
    step(1, 0, 10'd20, 0, 0, 0, 0, 0, 0, 0, 32'hA0A0_0005, 1);
    step(0, 0, 0, 0, 1, 0, 10'd21, 0, 0, 1, 32'hB0B0_B0B0, 1);
    idle();

    // Reset during a pending host read: the return is dropped.
    step(0, 0, 0, 0, 1, 0, 10'd5, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    arst = 1'b1; ext_req = 1; cpu_req = 0;
    #3;
    check("mid_ext_rvalid", {31'b0, ext_rvalid}, 32'd0);
    check("mid_ext_rdata", ext_rdata, 32'd0);
    check("mid_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    check("mid_ext_gnt", {31'b0, ext_gnt}, 32'd1);
    cpu_req = 1; #1;
    check("mid_starve_clear_gnt", {31'b0, ext_gnt}, 32'd0);
    check("mid_starve_clear_stall", {31'b0, cpu_stall}, 32'd0);
    @(posedge clk);
    #1;
    arst = 1'b0; cpu_req = 0; ext_req = 0;
    #3;
    check("post_rst_ext_rvalid", {31'b0, ext_rvalid}, 32'd0);
    contention();

    // Quiet bus.
    for (int i = 0; i < 10; i++) idle();

    repeat (2) @(negedge clk);
    check("cpu_q_drained", cpu_q.size(), 32'd0);
    check("ext_q_drained", ext_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
